cpu10_ex_wb_pipe: RTL and testbench

- Execute/memory/writeback datapath slice of the 3-stage 10-bit pipelined CPU.
- Contains three parts:
  - the FD->EM pipeline register;
  - the EM-stage ALU with forwarding operand muxes and data-memory interface drive;
  - the EM->WB pipeline register with writeback data select.
- Sits between the fetch/decode logic (register file, decoder) and the external data RAM/forwarding unit.

---
 rtl/cpu10_ex_wb_pipe.sv | 147 ++++++++++++++
 tb/tb_cpu10_ex_wb_pipe.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu10_ex_wb_pipe.sv
// EM/WB datapath slice of the 10-bit 3-stage CPU: FD->EM register, forwarding ALU, EM->WB register.
// Optional macro EX_FLUSH_EN adds a flush input that loads a bubble into the FD->EM register.
module cpu10_ex_wb_pipe #(
  parameter int DW = 10,
  parameter int RW = 3
) (
`ifdef EX_FLUSH_EN
  input  logic          flush,
`endif
  input  logic          clk,
  input  logic          reset,
  input  logic [RW-1:0] fd_srcA_addr,
  input  logic [RW-1:0] fd_dest_addr,
  input  logic [DW-1:0] fd_opA,
  input  logic [DW-1:0] fd_opB,
  input  logic [2:0]    fd_alu_ctrl,
  input  logic          fd_reg_we,
  input  logic          fd_mem_we,
  input  logic          fd_mem_re,
  input  logic [DW-1:0] fd_store_data,
  input  logic          forwardA,
  input  logic          forwardB,
  input  logic [DW-1:0] mem_rdata,
  output logic [RW-1:0] em_srcA_addr,
  output logic [RW-1:0] em_dest_addr,
  output logic [DW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  output logic          em_halt,
  output logic [RW-1:0] wb_dest,
  output logic          wb_we,
  output logic [DW-1:0] wb_wdata
);

  localparam logic [3:0] SHAMT_LIMIT = 4'(DW);

  logic          bubble;
  logic [RW-1:0] em_srca_reg;
  logic [RW-1:0] em_dest_reg;
  logic [DW-1:0] em_opa_reg;
  logic [DW-1:0] em_opb_reg;
  logic [2:0]    em_ctrl_reg;
  logic          em_reg_we_reg;
  logic          em_mem_we_reg;
  logic          em_mem_re_reg;
  logic [DW-1:0] em_store_reg;

  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [3:0]    shamt;
  logic [DW-1:0] alu_result;
  logic          alu_halt;

  logic [DW-1:0] wb_alu_reg;
  logic [DW-1:0] wb_rdata_reg;
  logic          wb_we_reg;
  logic          wb_mem_re_reg;
  logic [RW-1:0] wb_dest_reg;

`ifdef EX_FLUSH_EN
  assign bubble = flush;
`else
  assign bubble = 1'b0;
`endif

  // A bubble is an all-zero instruction: ADD 0+0 with no register or memory write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      em_srca_reg   <= '0;
      em_dest_reg   <= '0;
      em_opa_reg    <= '0;
      em_opb_reg    <= '0;
      em_ctrl_reg   <= '0;
      em_reg_we_reg <= 1'b0;
      em_mem_we_reg <= 1'b0;
      em_mem_re_reg <= 1'b0;
      em_store_reg  <= '0;
    end else if (bubble) begin
      em_srca_reg   <= '0;
      em_dest_reg   <= '0;
      em_opa_reg    <= '0;
      em_opb_reg    <= '0;
      em_ctrl_reg   <= '0;
      em_reg_we_reg <= 1'b0;
      em_mem_we_reg <= 1'b0;
      em_mem_re_reg <= 1'b0;
      em_store_reg  <= '0;
    end else begin
      em_srca_reg   <= fd_srcA_addr;
      em_dest_reg   <= fd_dest_addr;
      em_opa_reg    <= fd_opA;
      em_opb_reg    <= fd_opB;
      em_ctrl_reg   <= fd_alu_ctrl;
      em_reg_we_reg <= fd_reg_we;
      em_mem_we_reg <= fd_mem_we;
      em_mem_re_reg <= fd_mem_re;
      em_store_reg  <= fd_store_data;
    end
  end

  assign alu_a = forwardA ? wb_wdata : em_opa_reg;
  assign alu_b = forwardB ? wb_wdata : em_opb_reg;
  assign shamt = alu_b[3:0];

  always_comb begin
    alu_result = '0;
    alu_halt   = 1'b0;
    case (em_ctrl_reg)
      3'b000: alu_result = alu_a + alu_b;
      3'b001: alu_result = alu_a - alu_b;
      3'b010: alu_result = {{(DW-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
      3'b011: alu_result = ~(alu_a & alu_b);
      3'b100: alu_result = (shamt >= SHAMT_LIMIT) ? '0 : (alu_a >> shamt);
      3'b101: alu_result = (shamt >= SHAMT_LIMIT) ? '0 : (alu_a << shamt);
      3'b110: alu_halt   = 1'b1;
      default: alu_result = '0;
    endcase
  end

  assign em_srcA_addr = em_srca_reg;
  assign em_dest_addr = em_dest_reg;
  assign mem_addr     = alu_result;
  assign mem_we       = em_mem_we_reg;
  assign mem_wdata    = em_mem_we_reg ? em_store_reg : '0;
  assign em_halt      = alu_halt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_alu_reg    <= '0;
      wb_rdata_reg  <= '0;
      wb_we_reg     <= 1'b0;
      wb_mem_re_reg <= 1'b0;
      wb_dest_reg   <= '0;
    end else begin
      wb_alu_reg    <= alu_result;
      wb_rdata_reg  <= mem_rdata;
      wb_we_reg     <= em_reg_we_reg;
      wb_mem_re_reg <= em_mem_re_reg;
      wb_dest_reg   <= em_dest_reg;
    end
  end

  assign wb_dest  = wb_dest_reg;
  assign wb_we    = wb_we_reg;
  assign wb_wdata = wb_mem_re_reg ? wb_rdata_reg : wb_alu_reg;

endmodule

// File: tb/tb_cpu10_ex_wb_pipe.sv
// Scoreboard bench for cpu10_ex_wb_pipe: directed instruction table, queued expectations, negedge monitor.
module tb_cpu10_ex_wb_pipe;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] fd_srcA_addr, fd_dest_addr, fd_alu_ctrl;
  logic [9:0] fd_opA, fd_opB, fd_store_data, mem_rdata;
  logic       fd_reg_we, fd_mem_we, fd_mem_re, forwardA, forwardB;
  logic [2:0] em_srcA_addr, em_dest_addr, wb_dest;
  logic [9:0] mem_addr, mem_wdata, wb_wdata;
  logic       mem_we, em_halt, wb_we;
`ifdef EX_FLUSH_EN
  logic       flush = 1'b0;
`endif

  int checks = 0;
  int failures = 0;

  cpu10_ex_wb_pipe dut (
`ifdef EX_FLUSH_EN
    .flush(flush),
`endif
    .clk(clk), .reset(reset),
    .fd_srcA_addr(fd_srcA_addr), .fd_dest_addr(fd_dest_addr),
    .fd_opA(fd_opA), .fd_opB(fd_opB), .fd_alu_ctrl(fd_alu_ctrl),
    .fd_reg_we(fd_reg_we), .fd_mem_we(fd_mem_we), .fd_mem_re(fd_mem_re),
    .fd_store_data(fd_store_data), .forwardA(forwardA), .forwardB(forwardB),
    .mem_rdata(mem_rdata), .em_srcA_addr(em_srcA_addr), .em_dest_addr(em_dest_addr),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .em_halt(em_halt),
    .wb_dest(wb_dest), .wb_we(wb_we), .wb_wdata(wb_wdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] a, b;
    logic [2:0] ctrl;
    logic       rwe, mwe, mre;
    logic [9:0] sd;
    logic [2:0] src, dst;
    logic       fa, fb;
    logic [9:0] rdata;
    logic [9:0] exp_addr;
    logic       exp_halt;
  } vec_t;

  typedef struct {
    int         id;
    logic [9:0] addr;
    logic       mwe;
    logic [9:0] wdata;
    logic       halt;
    logic [2:0] src, dst;
  } em_exp_t;

  typedef struct {
    int         id;
    logic       we;
    logic [2:0] dst;
    logic [9:0] wdata;
  } wb_exp_t;

  vec_t    tbl[$];
  em_exp_t em_q[$];
  wb_exp_t wb_q[$];
  logic    issued = 1'b0;
  logic    em_v = 1'b0;
  logic    wb_v = 1'b0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Valid tracking for the monitor; mirrors the DUT's reset discard of in-flight slots.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      em_v <= 1'b0;
      wb_v <= 1'b0;
    end else begin
      em_v <= issued;
      wb_v <= em_v;
    end
  end

  always @(negedge clk) begin
    if (em_v) begin
      if (em_q.size() == 0) chk("em_queue_empty", 16'd1, 16'd0);
      else begin
        em_exp_t e;
        e = em_q.pop_front();
        $display("EM  #%0d addr=%h mem_we=%b wdata=%h halt=%b", e.id, mem_addr, mem_we, mem_wdata, em_halt);
        chk("mem_addr", 16'(mem_addr), 16'(e.addr));
        chk("mem_we", 16'(mem_we), 16'(e.mwe));
        chk("mem_wdata", 16'(mem_wdata), 16'(e.wdata));
        chk("em_halt", 16'(em_halt), 16'(e.halt));
        chk("em_srcA_addr", 16'(em_srcA_addr), 16'(e.src));
        chk("em_dest_addr", 16'(em_dest_addr), 16'(e.dst));
      end
    end
    if (wb_v) begin
      if (wb_q.size() == 0) chk("wb_queue_empty", 16'd1, 16'd0);
      else begin
        wb_exp_t w;
        w = wb_q.pop_front();
        $display("WB  #%0d we=%b dest=%0d wdata=%h", w.id, wb_we, wb_dest, wb_wdata);
        chk("wb_we", 16'(wb_we), 16'(w.we));
        chk("wb_dest", 16'(wb_dest), 16'(w.dst));
        chk("wb_wdata", 16'(wb_wdata), 16'(w.wdata));
      end
    end
  end

  task automatic add(input logic [9:0] a, b, input logic [2:0] ctrl, input logic rwe, mwe, mre,
                     input logic [9:0] sd, input logic [2:0] src, dst, input logic fa, fb,
                     input logic [9:0] rdata, exp_addr, input logic exp_halt);
    vec_t v;
    v = '{a, b, ctrl, rwe, mwe, mre, sd, src, dst, fa, fb, rdata, exp_addr, exp_halt};
    tbl.push_back(v);
  endtask

  task automatic drive_fd(input vec_t v);
    fd_opA = v.a; fd_opB = v.b; fd_alu_ctrl = v.ctrl;
    fd_reg_we = v.rwe; fd_mem_we = v.mwe; fd_mem_re = v.mre;
    fd_store_data = v.sd; fd_srcA_addr = v.src; fd_dest_addr = v.dst;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_mem_addr"}, 16'(mem_addr), 16'd0);
    chk({tag, "_mem_we"}, 16'(mem_we), 16'd0);
    chk({tag, "_mem_wdata"}, 16'(mem_wdata), 16'd0);
    chk({tag, "_em_halt"}, 16'(em_halt), 16'd0);
    chk({tag, "_em_srcA"}, 16'(em_srcA_addr), 16'd0);
    chk({tag, "_em_dest"}, 16'(em_dest_addr), 16'd0);
    chk({tag, "_wb_we"}, 16'(wb_we), 16'd0);
    chk({tag, "_wb_dest"}, 16'(wb_dest), 16'd0);
    chk({tag, "_wb_wdata"}, 16'(wb_wdata), 16'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    // a      b      op    rwe mwe mre sd      src   dst   fa fb rdata   addr    halt
    add(10'h005, 10'h003, 3'b000, 1, 0, 0, 10'h011, 3'd2, 3'd5, 0, 0, 10'h2AA, 10'h008, 0); // ADD
    add(10'h000, 10'h001, 3'b000, 1, 0, 0, 10'h022, 3'd5, 3'd1, 1, 0, 10'h2AA, 10'h009, 0); // fwdA 8+1
    add(10'h003, 10'h005, 3'b001, 0, 0, 0, 10'h033, 3'd1, 3'd2, 0, 0, 10'h2AA, 10'h3FE, 0); // SUB
    add(10'h003, 10'h005, 3'b010, 1, 0, 0, 10'h044, 3'd3, 3'd3, 0, 0, 10'h2AA, 10'h001, 0); // SLT
    add(10'h3FF, 10'h001, 3'b010, 1, 0, 0, 10'h055, 3'd4, 3'd4, 0, 0, 10'h2AA, 10'h001, 0); // SLT -1<1
    add(10'h3F0, 10'h0FF, 3'b011, 1, 0, 0, 10'h066, 3'd6, 3'd7, 0, 0, 10'h2AA, 10'h30F, 0); // NAND
    add(10'h001, 10'h003, 3'b101, 1, 0, 0, 10'h077, 3'd7, 3'd6, 0, 0, 10'h2AA, 10'h008, 0); // SLL 3
    add(10'h200, 10'h009, 3'b100, 1, 0, 0, 10'h088, 3'd0, 3'd5, 0, 0, 10'h2AA, 10'h001, 0); // SLR 9
    add(10'h001, 10'h00C, 3'b101, 1, 0, 0, 10'h099, 3'd1, 3'd4, 0, 0, 10'h2AA, 10'h000, 0); // SLL 12
    add(10'h3FF, 10'h00A, 3'b100, 1, 0, 0, 10'h0AA, 3'd2, 3'd3, 0, 0, 10'h2AA, 10'h000, 0); // SLR 10
    add(10'h004, 10'h002, 3'b000, 0, 1, 0, 10'h007, 3'd3, 3'd2, 0, 0, 10'h2AA, 10'h006, 0); // store
    add(10'h001, 10'h001, 3'b000, 1, 0, 1, 10'h3FF, 3'd4, 3'd6, 0, 0, 10'h155, 10'h002, 0); // load
    add(10'h000, 10'h001, 3'b000, 1, 0, 0, 10'h0BB, 3'd6, 3'd0, 1, 0, 10'h2AA, 10'h156, 0); // fwd load
    add(10'h005, 10'h003, 3'b110, 0, 0, 0, 10'h0CC, 3'd5, 3'd3, 0, 0, 10'h2AA, 10'h000, 1); // HALT
    add(10'h005, 10'h003, 3'b111, 0, 0, 0, 10'h0DD, 3'd5, 3'd3, 0, 0, 10'h2AA, 10'h000, 0); // op 111
    add(10'h007, 10'h009, 3'b000, 1, 0, 0, 10'h0EE, 3'd1, 3'd1, 0, 0, 10'h2AA, 10'h010, 0); // ADD
    add(10'h000, 10'h000, 3'b000, 1, 0, 0, 10'h0FF, 3'd1, 3'd2, 1, 1, 10'h2AA, 10'h020, 0); // fwd A+B
    add(10'h030, 10'h000, 3'b001, 1, 0, 0, 10'h101, 3'd2, 3'd3, 0, 1, 10'h2AA, 10'h010, 0); // fwdB SUB

    // Reset held with nonzero inputs: everything must read 0.
    reset = 1'b0;
    forwardA = 1'b0; forwardB = 1'b0; mem_rdata = 10'h155;
    drive_fd(tbl[0]);
    fd_mem_we = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    $display("RST hold mem_addr=%h wb_we=%b wb_wdata=%h", mem_addr, wb_we, wb_wdata);
    check_all_zero("reset");
    reset = 1'b1;

    for (int i = 0; i <= tbl.size(); i++) begin
      if (i < tbl.size()) begin
        em_exp_t e;
        wb_exp_t w;
        v = tbl[i];
        drive_fd(v);
        issued = 1'b1;
        e = '{i, v.exp_addr, v.mwe, (v.mwe ? v.sd : 10'h000), v.exp_halt, v.src, v.dst};
        w = '{i, v.rwe, v.dst, (v.mre ? v.rdata : v.exp_addr)};
        em_q.push_back(e);
        wb_q.push_back(w);
      end else begin
        issued = 1'b0;
      end
      if (i > 0) begin
        v = tbl[i-1];
        forwardA = v.fa; forwardB = v.fb; mem_rdata = v.rdata;
      end
      @(posedge clk);
      #2;
    end
    forwardA = 1'b0; forwardB = 1'b0;
    @(posedge clk);
    #2;
    chk("em_queue_drained", 16'(em_q.size()), 16'd0);
    chk("wb_queue_drained", 16'(wb_q.size()), 16'd0);

    // Mid-operation reset discards both stages asynchronously.
    add(10'h005, 10'h003, 3'b000, 1, 0, 0, 10'h000, 3'd2, 3'd5, 0, 0, 10'h000, 10'h008, 0);
    drive_fd(tbl[tbl.size()-1]);
    repeat (2) @(posedge clk);
    #2;
    chk("pre_reset_wb_we", 16'(wb_we), 16'd1);
    chk("pre_reset_wb_wdata", 16'(wb_wdata), 16'h008);
    #1 reset = 1'b0;
    #1;
    $display("RST mid mem_addr=%h wb_we=%b wb_wdata=%h", mem_addr, wb_we, wb_wdata);
    check_all_zero("midreset");
    @(posedge clk);
    #2;
    fd_alu_ctrl = 3'b001; fd_opA = 10'h009; fd_opB = 10'h004;
    reset = 1'b1;
    @(posedge clk);
    #2;
    $display("REL mem_addr=%h wb_we=%b", mem_addr, wb_we);
    chk("release_capture_mem_addr", 16'(mem_addr), 16'h005);
    chk("release_wb_we", 16'(wb_we), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
